// File: rtl/enemy_pool_pkg.sv
// Shared types and defaults for the enemy pool: FSM state encoding, default
// sprite geometry and colour, and the Galois LFSR step function.
// Optional feature macro: ENEMY_ZIGZAG_EN (horizontal zig-zag motion).
package enemy_pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_SPAWN = 2'd2
    } state_e;

    localparam int          NUM_ENEMY_DEF = 4;
    localparam int          SPR_W_DEF     = 32;
    localparam int          SPR_H_DEF     = 24;
    localparam logic [11:0] ENEMY_RGB_DEF = 12'hF00;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    endfunction

endpackage

// File: rtl/enemy_pool_if.sv
// Frame/pixel/hit bus between the display side (master) and the enemy pool
// (slave). Clock and reset stay plain ports on the modules.
// Optional feature macro: ENEMY_ZIGZAG_EN (no effect on this interface).
interface enemy_pool_if #(
    parameter int NUM_ENEMY = 4,
    parameter int X_W       = 11,
    parameter int Y_W       = 10
);
    logic                 frame_tick_i;
    logic                 en_i;
    logic [X_W-1:0]       req_x_addr_i;
    logic [Y_W-1:0]       req_y_addr_i;
    logic                 hit_valid_i;
    logic [X_W-1:0]       hit_x_i;
    logic [Y_W-1:0]       hit_y_i;
    logic [NUM_ENEMY-1:0] alive_o;
    logic                 kill_o;
    logic                 escape_o;
    logic                 vga_alpha_o;
    logic [11:0]          vga_rgb_o;

    modport master (
        output frame_tick_i, en_i, req_x_addr_i, req_y_addr_i,
               hit_valid_i, hit_x_i, hit_y_i,
        input  alive_o, kill_o, escape_o, vga_alpha_o, vga_rgb_o
    );

    modport slave (
        input  frame_tick_i, en_i, req_x_addr_i, req_y_addr_i,
               hit_valid_i, hit_x_i, hit_y_i,
        output alive_o, kill_o, escape_o, vga_alpha_o, vga_rgb_o
    );
endinterface

// File: rtl/enemy_pool_lfsr16.sv
// Free-running 16-bit Galois LFSR, advanced every clock, used as the spawn
// position (and spawn direction) source.
// Optional feature macro: ENEMY_ZIGZAG_EN (no effect on this module).
module enemy_pool_lfsr16
    import enemy_pool_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);
    logic [15:0] r_q;

    // Step the LFSR once per clock; reload the seed on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= SEED;
        end else begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;
endmodule

// File: rtl/enemy_pool.sv
// Enemy pool: NUM_ENEMY slots that spawn at pseudo-random x, fall once per
// frame, die on bullet hits or when leaving the bottom edge, and answer the
// display controller's per-pixel coverage query one clock later.
// Optional feature macro: ENEMY_ZIGZAG_EN (per-slot direction bit, x steps +-1
// each frame and bounces at the screen edges).
module enemy_pool
    import enemy_pool_pkg::*;
#(
    parameter int          NUM_ENEMY    = NUM_ENEMY_DEF,
    parameter int          X_W          = 11,
    parameter int          Y_W          = 10,
    parameter int          H_DISP       = 800,
    parameter int          V_DISP       = 600,
    parameter int          SPR_W        = SPR_W_DEF,
    parameter int          SPR_H        = SPR_H_DEF,
    parameter int          SPEED        = 2,
    parameter int          SPAWN_PERIOD = 90,
    parameter logic [11:0] ENEMY_RGB    = ENEMY_RGB_DEF,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    enemy_pool_if.slave  bus
);
    localparam int             IDX_W      = (NUM_ENEMY > 1) ? $clog2(NUM_ENEMY) : 1;
    localparam int             FC_W       = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENEMY - 1);
    localparam logic [FC_W-1:0]  LAST_FRM = FC_W'(SPAWN_PERIOD - 1);
    localparam logic [X_W:0]   SPR_W_X    = (X_W + 1)'(SPR_W);
    localparam logic [Y_W:0]   SPR_H_Y    = (Y_W + 1)'(SPR_H);
    localparam logic [Y_W:0]   V_DISP_Y   = (Y_W + 1)'(V_DISP);
    localparam logic [Y_W:0]   SPEED_Y    = (Y_W + 1)'(SPEED);
    localparam logic [X_W-1:0] X_RANGE    = X_W'(H_DISP - SPR_W);

    // Point-in-box test with one guard bit so box edges never wrap.
    function automatic logic in_box(input logic [X_W-1:0] ox, input logic [Y_W-1:0] oy,
                                    input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
        logic [X_W:0] ox_e, px_e;
        logic [Y_W:0] oy_e, py_e;
        ox_e = {1'b0, ox};
        px_e = {1'b0, px};
        oy_e = {1'b0, oy};
        py_e = {1'b0, py};
        return (ox_e <= px_e) && (px_e < ox_e + SPR_W_X) &&
               (oy_e <= py_e) && (py_e < oy_e + SPR_H_Y);
    endfunction

    state_e               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [FC_W-1:0]      r_frame_cnt;
    logic [NUM_ENEMY-1:0] r_alive;
    logic [X_W-1:0]       r_x [NUM_ENEMY];
    logic [Y_W-1:0]       r_y [NUM_ENEMY];
`ifdef ENEMY_ZIGZAG_EN
    logic [NUM_ENEMY-1:0] r_dir;
`endif
    logic                 r_pend_v;
    logic [X_W-1:0]       r_pend_x;
    logic [Y_W-1:0]       r_pend_y;
    logic                 r_kill;
    logic                 r_escape;
    logic                 r_alpha;
    logic [11:0]          r_rgb;

    logic [15:0]          w_lfsr_q;
    logic                 w_lfsr_unused;
    logic [X_W-1:0]       w_l0, w_l1, w_l2;
    logic [Y_W:0]         w_ny;
    logic                 w_probe_v;
    logic [X_W-1:0]       w_probe_x;
    logic [Y_W-1:0]       w_probe_y;
    logic [NUM_ENEMY-1:0] w_pix_cov;
    logic [NUM_ENEMY-1:0] w_match;
    logic [NUM_ENEMY-1:0] w_kill_oh;
    logic [NUM_ENEMY-1:0] w_dead;
    logic [NUM_ENEMY-1:0] w_spawn_oh;
    logic                 w_pix_any;

    enemy_pool_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr_q)
    );

    assign w_lfsr_unused = ^w_lfsr_q;

    // Fold the raw LFSR x into the legal spawn range with at most two subtractions.
    assign w_l0 = w_lfsr_q[X_W-1:0];
    assign w_l1 = (w_l0 >= X_RANGE) ? (w_l0 - X_RANGE) : w_l0;
    assign w_l2 = (w_l1 >= X_RANGE) ? (w_l1 - X_RANGE) : w_l1;

    assign w_ny = {1'b0, r_y[r_idx]} + SPEED_Y;

    // Hit source: in IDLE a pending probe takes precedence over a live one; elsewhere hits only queue.
    always_comb begin
        if (r_state == ST_IDLE) begin
            if (r_pend_v) begin
                w_probe_v = 1'b1;
                w_probe_x = r_pend_x;
                w_probe_y = r_pend_y;
            end else begin
                w_probe_v = bus.hit_valid_i;
                w_probe_x = bus.hit_x_i;
                w_probe_y = bus.hit_y_i;
            end
        end else begin
            w_probe_v = 1'b0;
            w_probe_x = bus.hit_x_i;
            w_probe_y = bus.hit_y_i;
        end
    end

    // Per-slot coverage for the pixel query and the hit probe.
    always_comb begin
        w_pix_cov = '0;
        w_match   = '0;
        for (int i = 0; i < NUM_ENEMY; i++) begin
            w_pix_cov[i] = r_alive[i] & in_box(r_x[i], r_y[i], bus.req_x_addr_i, bus.req_y_addr_i);
            w_match[i]   = w_probe_v & r_alive[i] & in_box(r_x[i], r_y[i], w_probe_x, w_probe_y);
        end
    end

    // Lowest set bit isolates the lowest-index hit slot and the lowest-index free slot.
    assign w_pix_any  = |w_pix_cov;
    assign w_kill_oh  = w_match & (~w_match + NUM_ENEMY'(1));
    assign w_dead     = ~r_alive;
    assign w_spawn_oh = w_dead & (~w_dead + NUM_ENEMY'(1));

    // Frame update FSM, hit handling and registered pixel/event outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_alive     <= '0;
            for (int i = 0; i < NUM_ENEMY; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
`ifdef ENEMY_ZIGZAG_EN
            r_dir       <= '0;
`endif
            r_pend_v    <= 1'b0;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_kill      <= 1'b0;
            r_escape    <= 1'b0;
            r_alpha     <= 1'b0;
            r_rgb       <= 12'h000;
        end else begin
            r_kill   <= 1'b0;
            r_escape <= 1'b0;
            r_alpha  <= bus.en_i & w_pix_any;
            r_rgb    <= (bus.en_i & w_pix_any) ? ENEMY_RGB : 12'h000;
            case (r_state)
                ST_IDLE: begin
                    if (w_kill_oh != '0) begin
                        r_alive <= r_alive & ~w_kill_oh;
                        r_kill  <= 1'b1;
                    end
                    // Pending probe is consumed now; a simultaneous new probe takes its place.
                    if (r_pend_v) begin
                        r_pend_v <= bus.hit_valid_i;
                        r_pend_x <= bus.hit_x_i;
                        r_pend_y <= bus.hit_y_i;
                    end
                    if (bus.frame_tick_i) begin
                        r_state <= ST_MOVE;
                        r_idx   <= '0;
                    end
                end
                ST_MOVE: begin
                    if (bus.hit_valid_i) begin
                        r_pend_v <= 1'b1;
                        r_pend_x <= bus.hit_x_i;
                        r_pend_y <= bus.hit_y_i;
                    end
                    if (r_alive[r_idx]) begin
                        if (w_ny >= V_DISP_Y) begin
                            r_alive[r_idx] <= 1'b0;
                            r_escape       <= 1'b1;
                        end else begin
                            r_y[r_idx] <= w_ny[Y_W-1:0];
                        end
`ifdef ENEMY_ZIGZAG_EN
                        if (r_dir[r_idx]) begin
                            if (r_x[r_idx] == X_RANGE) begin
                                r_dir[r_idx] <= 1'b0;
                                r_x[r_idx]   <= r_x[r_idx] - X_W'(1);
                            end else begin
                                r_x[r_idx]   <= r_x[r_idx] + X_W'(1);
                            end
                        end else begin
                            if (r_x[r_idx] == '0) begin
                                r_dir[r_idx] <= 1'b1;
                                r_x[r_idx]   <= r_x[r_idx] + X_W'(1);
                            end else begin
                                r_x[r_idx]   <= r_x[r_idx] - X_W'(1);
                            end
                        end
`endif
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_SPAWN;
                        r_idx   <= '0;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                ST_SPAWN: begin
                    if (bus.hit_valid_i) begin
                        r_pend_v <= 1'b1;
                        r_pend_x <= bus.hit_x_i;
                        r_pend_y <= bus.hit_y_i;
                    end
                    if (r_frame_cnt == LAST_FRM) begin
                        r_frame_cnt <= '0;
                        for (int i = 0; i < NUM_ENEMY; i++) begin
                            if (w_spawn_oh[i]) begin
                                r_alive[i] <= 1'b1;
                                r_y[i]     <= '0;
                                r_x[i]     <= w_l2;
`ifdef ENEMY_ZIGZAG_EN
                                r_dir[i]   <= w_lfsr_q[15];
`endif
                            end
                        end
                    end else begin
                        r_frame_cnt <= r_frame_cnt + FC_W'(1);
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign bus.alive_o     = r_alive;
    assign bus.kill_o      = r_kill;
    assign bus.escape_o    = r_escape;
    assign bus.vga_alpha_o = r_alpha;
    assign bus.vga_rgb_o   = r_rgb;

endmodule

// File: tb/tb_enemy_pool.sv
// Self-checking bench for enemy_pool: two instances (default spawn period and a
// short one that fills the pool quickly) driven with the same random stimulus
// and compared every cycle against a frame/pass-level reference model.
// Optional feature macro: ENEMY_ZIGZAG_EN (model follows the same build).
module tb_enemy_pool;
    localparam int N   = 4;
    localparam int X_W = 11;
    localparam int Y_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           tick, en, hv;
    logic [X_W-1:0] rx, hx;
    logic [Y_W-1:0] ry, hy;
    int             checks   = 0;
    int             failures = 0;

    enemy_pool_if #(.NUM_ENEMY(N), .X_W(X_W), .Y_W(Y_W)) if_a ();
    enemy_pool_if #(.NUM_ENEMY(N), .X_W(X_W), .Y_W(Y_W)) if_b ();

    assign if_a.frame_tick_i = tick;  assign if_b.frame_tick_i = tick;
    assign if_a.en_i         = en;    assign if_b.en_i         = en;
    assign if_a.req_x_addr_i = rx;    assign if_b.req_x_addr_i = rx;
    assign if_a.req_y_addr_i = ry;    assign if_b.req_y_addr_i = ry;
    assign if_a.hit_valid_i  = hv;    assign if_b.hit_valid_i  = hv;
    assign if_a.hit_x_i      = hx;    assign if_b.hit_x_i      = hx;
    assign if_a.hit_y_i      = hy;    assign if_b.hit_y_i      = hy;

    enemy_pool #(.NUM_ENEMY(N)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    enemy_pool #(.NUM_ENEMY(N), .SPAWN_PERIOD(4)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    logic [37:0] obs;
    assign obs = {if_a.alive_o, if_a.kill_o, if_a.escape_o, if_a.vga_alpha_o, if_a.vga_rgb_o,
                  if_b.alive_o, if_b.kill_o, if_b.escape_o, if_b.vga_alpha_o, if_b.vga_rgb_o};

    // Reference model state: instance 0 = period 90, instance 1 = period 4.
    bit          m_alive [2][N];
    int          m_x     [2][N];
    int          m_y     [2][N];
    bit          m_dir   [2][N];
    int          m_ph    [2];     // 0 idle, 1..N moving slot ph-1, N+1 spawn
    int          m_cnt   [2];
    bit          m_pv    [2];
    int          m_px    [2];
    int          m_py    [2];
    int          m_period[2] = '{90, 4};
    logic [15:0] m_lfsr;
    bit          e_kill [2], e_esc [2], e_alpha [2];
    logic [11:0] e_rgb  [2];

    function automatic bit m_in(int ox, int oy, int px, int py);
        return px >= ox && px < ox + 32 && py >= oy && py < oy + 24;
    endfunction

    function automatic logic [37:0] exp_vec();
        logic [3:0] al [2];
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) al[k][i] = m_alive[k][i];
        return {al[0], e_kill[0], e_esc[0], e_alpha[0], e_rgb[0],
                al[1], e_kill[1], e_esc[1], e_alpha[1], e_rgb[1]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                m_alive[k][i] = 0; m_x[k][i] = 0; m_y[k][i] = 0; m_dir[k][i] = 0;
            end
            m_ph[k] = 0; m_cnt[k] = 0; m_pv[k] = 0; m_px[k] = 0; m_py[k] = 0;
            e_kill[k] = 0; e_esc[k] = 0; e_alpha[k] = 0; e_rgb[k] = 12'h000;
        end
        m_lfsr = 16'hACE1;
    endtask

    // One clock of the model, using the inputs currently driven.
    task automatic model_cycle();
        for (int k = 0; k < 2; k++) begin
            bit cov = 0;
            for (int i = 0; i < N; i++)
                if (m_alive[k][i] && m_in(m_x[k][i], m_y[k][i], int'(rx), int'(ry))) cov = 1;
            e_alpha[k] = en && cov;
            e_rgb[k]   = e_alpha[k] ? 12'hF00 : 12'h000;
            e_kill[k]  = 0;
            e_esc[k]   = 0;
            if (m_ph[k] == 0) begin
                bit pv; int px, py; bit done = 0;
                if (m_pv[k]) begin
                    pv = 1; px = m_px[k]; py = m_py[k];
                    m_pv[k] = hv; m_px[k] = int'(hx); m_py[k] = int'(hy);
                end else begin
                    pv = hv; px = int'(hx); py = int'(hy);
                end
                for (int i = 0; i < N; i++)
                    if (pv && !done && m_alive[k][i] && m_in(m_x[k][i], m_y[k][i], px, py)) begin
                        m_alive[k][i] = 0; e_kill[k] = 1; done = 1;
                    end
                if (tick) m_ph[k] = 1;
            end else begin
                if (hv) begin m_pv[k] = 1; m_px[k] = int'(hx); m_py[k] = int'(hy); end
                if (m_ph[k] <= N) begin
                    int i = m_ph[k] - 1;
                    if (m_alive[k][i]) begin
                        if (m_y[k][i] + 2 >= 600) begin m_alive[k][i] = 0; e_esc[k] = 1; end
                        else m_y[k][i] = m_y[k][i] + 2;
`ifdef ENEMY_ZIGZAG_EN
                        if (m_dir[k][i]) begin
                            if (m_x[k][i] == 768) begin m_dir[k][i] = 0; m_x[k][i] -= 1; end
                            else m_x[k][i] += 1;
                        end else begin
                            if (m_x[k][i] == 0) begin m_dir[k][i] = 1; m_x[k][i] = 1; end
                            else m_x[k][i] -= 1;
                        end
`endif
                    end
                    m_ph[k] = m_ph[k] + 1;
                end else begin
                    if (m_cnt[k] == m_period[k] - 1) begin
                        bit done = 0;
                        int l = int'(m_lfsr) % 2048;
                        while (l >= 768) l -= 768;
                        m_cnt[k] = 0;
                        for (int i = 0; i < N; i++)
                            if (!done && !m_alive[k][i]) begin
                                m_alive[k][i] = 1; m_y[k][i] = 0; m_x[k][i] = l;
                                m_dir[k][i] = m_lfsr[15]; done = 1;
                            end
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                    m_ph[k] = 0;
                end
            end
        end
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    // Point inside (or just around) a random live slot of instance k, else anywhere on screen.
    task automatic pick_point(input int k, output logic [X_W-1:0] px, output logic [Y_W-1:0] py);
        int i = int'($urandom_range(0, N - 1));
        if (m_alive[k][i] && $urandom_range(0, 3) != 0) begin
            px = X_W'(m_x[k][i] + int'($urandom_range(0, 33)) - 1);
            py = Y_W'(m_y[k][i] + int'($urandom_range(0, 25)) - 1);
        end else begin
            px = X_W'($urandom_range(0, 799));
            py = Y_W'($urandom_range(0, 599));
        end
    endtask

    task automatic set_random_inputs(input bit hits);
        tick = ($urandom_range(0, 2) == 0);
        en   = ($urandom_range(0, 7) != 0);
        pick_point(int'($urandom_range(0, 1)), rx, ry);
        hv   = hits && ($urandom_range(0, 29) == 0);
        pick_point(($urandom_range(0, 9) == 0) ? 0 : 1, hx, hy);
    endtask

    task automatic test_reset();
        rst = 1'b0; tick = 1'b1; en = 1'b1; hv = 1'b1;
        rx = '0; ry = '0; hx = '0; hy = '0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 38'd0) begin
                failures++;
                $display("FAIL reset cyc=%0d obs=%h exp=0", c, obs);
            end
        end
        rst = 1'b1;
        model_reset();
        tick = 1'b0; hv = 1'b0;
    endtask

    task automatic test_spawn_period();
        for (int f = 1; f <= 90; f++) begin
            for (int c = 0; c < 8; c++) begin
                tick = (c == 0); hv = 1'b0;
                en = ($urandom_range(0, 3) != 0);
                pick_point(int'($urandom_range(0, 1)), rx, ry);
                step();
                checks++;
                if (obs !== exp_vec()) begin
                    failures++;
                    $display("FAIL spawn_period frame=%0d cyc=%0d obs=%h exp=%h", f, c, obs, exp_vec());
                end
            end
            if (f == 89) begin
                checks++;
                if (if_a.alive_o !== 4'b0000) begin
                    failures++;
                    $display("FAIL no_spawn_before_90 alive=%b exp=0000", if_a.alive_o);
                end
            end
        end
        checks++;
        if (if_a.alive_o !== 4'b0001) begin
            failures++;
            $display("FAIL first_spawn alive=%b exp=0001", if_a.alive_o);
        end
        // Box edges of the fresh slot 0 (y=0): offsets {dx, dy, expected alpha}.
        for (int t = 0; t < 4; t++) begin
            int dx, dy; bit ea;
            case (t)
                0: begin dx = 0;  dy = 0;  ea = 1; end
                1: begin dx = 32; dy = 0;  ea = 0; end
                2: begin dx = 31; dy = 23; ea = 1; end
                default: begin dx = 31; dy = 24; ea = 0; end
            endcase
            tick = 1'b0; hv = 1'b0; en = 1'b1;
            rx = X_W'(m_x[0][0] + dx); ry = Y_W'(dy);
            step();
            checks++;
            if (if_a.vga_alpha_o !== ea || if_a.vga_rgb_o !== (ea ? 12'hF00 : 12'h000)) begin
                failures++;
                $display("FAIL slot0_pixel t=%0d alpha=%b rgb=%h exp_alpha=%b", t, if_a.vga_alpha_o, if_a.vga_rgb_o, ea);
            end
        end
    endtask

    task automatic test_hit_in_pass();
        int kd = 0, km = 0, tgt = -1;
        tick = 1'b0; hv = 1'b0;
        for (int c = 0; c < 8 && m_ph[1] != 0; c++) step();
        for (int i = N - 1; i >= 0; i--) if (m_alive[1][i]) tgt = i;
        tick = 1'b1; step();
        tick = 1'b0; step();
        if (tgt >= 0) begin
            hv = 1'b1;
            hx = X_W'(m_x[1][tgt] + 16);
            hy = Y_W'(m_y[1][tgt] + 12);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            hv = 1'b0;
            kd += int'(if_b.kill_o);
            km += int'(e_kill[1]);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL hit_in_pass cyc=%0d obs=%h exp=%h", c, obs, exp_vec());
            end
        end
        checks++;
        if (kd != km) begin
            failures++;
            $display("FAIL hit_in_pass_kills got=%0d exp=%0d", kd, km);
        end
    endtask

    task automatic test_random(input int ncyc, input bit hits);
        for (int c = 0; c < ncyc; c++) begin
            set_random_inputs(hits);
            step();
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL random hits=%0d cyc=%0d obs=%h exp=%h", hits, c, obs, exp_vec());
            end
        end
        tick = 1'b0; hv = 1'b0;
    endtask

    task automatic test_reset_mid_pass();
        tick = 1'b1; hv = 1'b0; step();
        tick = 1'b0; step();
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 38'd0) begin
            failures++;
            $display("FAIL reset_mid_pass obs=%h exp=0", obs);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        test_random(300, 1'b1);
    endtask

    initial begin
        test_reset();
        test_spawn_period();
        test_hit_in_pass();
        test_random(4000, 1'b0);
        test_random(3000, 1'b1);
        test_reset_mid_pass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
